// File: rtl/cndm_micro_pkg.sv
// Shared definitions for the Corundum-micro DMA statistics block:
// register index constants and the register-select enum.
package cndm_micro_pkg;

  localparam logic [3:0] CNDM_DMA_STAT_RD_OP_START = 4'd0;
  localparam logic [3:0] CNDM_DMA_STAT_RD_OP_DONE  = 4'd1;
  localparam logic [3:0] CNDM_DMA_STAT_RD_OP_ERR   = 4'd2;
  localparam logic [3:0] CNDM_DMA_STAT_RD_REQ      = 4'd3;
  localparam logic [3:0] CNDM_DMA_STAT_RD_BYTES    = 4'd4;
  localparam logic [3:0] CNDM_DMA_STAT_RD_TIMEOUT  = 4'd5;
  localparam logic [3:0] CNDM_DMA_STAT_RD_STALL    = 4'd6;
  localparam logic [3:0] CNDM_DMA_STAT_RD_INFLIGHT = 4'd7;
  localparam logic [3:0] CNDM_DMA_STAT_WR_OP_START = 4'd8;
  localparam logic [3:0] CNDM_DMA_STAT_WR_OP_DONE  = 4'd9;
  localparam logic [3:0] CNDM_DMA_STAT_WR_OP_ERR   = 4'd10;
  localparam logic [3:0] CNDM_DMA_STAT_WR_REQ      = 4'd11;
  localparam logic [3:0] CNDM_DMA_STAT_WR_BYTES    = 4'd12;
  localparam logic [3:0] CNDM_DMA_STAT_WR_STALL    = 4'd13;
  localparam logic [3:0] CNDM_DMA_STAT_WR_INFLIGHT = 4'd14;
  localparam logic [3:0] CNDM_DMA_STAT_PEAK        = 4'd15;

  typedef enum logic [3:0] {
    STAT_RD_OP_START = CNDM_DMA_STAT_RD_OP_START,
    STAT_RD_OP_DONE  = CNDM_DMA_STAT_RD_OP_DONE,
    STAT_RD_OP_ERR   = CNDM_DMA_STAT_RD_OP_ERR,
    STAT_RD_REQ      = CNDM_DMA_STAT_RD_REQ,
    STAT_RD_BYTES    = CNDM_DMA_STAT_RD_BYTES,
    STAT_RD_TIMEOUT  = CNDM_DMA_STAT_RD_TIMEOUT,
    STAT_RD_STALL    = CNDM_DMA_STAT_RD_STALL,
    STAT_RD_INFLIGHT = CNDM_DMA_STAT_RD_INFLIGHT,
    STAT_WR_OP_START = CNDM_DMA_STAT_WR_OP_START,
    STAT_WR_OP_DONE  = CNDM_DMA_STAT_WR_OP_DONE,
    STAT_WR_OP_ERR   = CNDM_DMA_STAT_WR_OP_ERR,
    STAT_WR_REQ      = CNDM_DMA_STAT_WR_REQ,
    STAT_WR_BYTES    = CNDM_DMA_STAT_WR_BYTES,
    STAT_WR_STALL    = CNDM_DMA_STAT_WR_STALL,
    STAT_WR_INFLIGHT = CNDM_DMA_STAT_WR_INFLIGHT,
    STAT_PEAK        = CNDM_DMA_STAT_PEAK
  } stat_reg_t;

endpackage

// File: rtl/cndm_micro_stat_ctr.sv
// One statistics counter. SAT=0: wrapping accumulator (value + inc - dec).
// SAT=1: in-flight style counter that floors at zero and holds at all-ones.
// clr zeroes the old value before this cycle's increment is applied, so a
// same-cycle event survives a clear.
module cndm_micro_stat_ctr
  import cndm_micro_pkg::*;
#(
  parameter int W   = 32,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] base_s;

  // Starting point for this cycle: zero when cleared, else the held value
  always_comb begin
    if (clr) begin
      base_s = '0;
    end else begin
      base_s = cnt_r;
    end
  end

  if (SAT) begin : g_sat
    localparam logic [W:0] ONE_WIDE = {{W{1'b0}}, 1'b1};
    logic [W:0] up_s;
    logic [W:0] dn_s;

    // Up/down with floor at zero and ceiling at all-ones (carry bit = overflow)
    always_comb begin
      up_s = {1'b0, base_s} + {1'b0, inc};
      if (dec && (up_s != '0)) begin
        dn_s = up_s - ONE_WIDE;
      end else begin
        dn_s = up_s;
      end
      if (dn_s[W]) begin
        nxt = '1;
      end else begin
        nxt = dn_s[W-1:0];
      end
    end
  end else begin : g_wrap
    // Plain modulo-2^W accumulation
    always_comb begin
      nxt = base_s + inc - W'(dec);
    end
  end

  // Counter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= nxt;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/cndm_micro_dma_stats.sv
// DMA statistics collector for the Corundum-micro PCIe core. Turns the
// per-cycle stat pulses/levels of the DMA interface into sixteen 32-bit
// registers readable through a one-cycle-latency port, with optional
// clear-on-read and a global clear that preserves in-flight accounting.
module cndm_micro_dma_stats
  import cndm_micro_pkg::*;
#(
  parameter int RD_OP_TAG_W = 6,
  parameter int WR_OP_TAG_W = 5,
  parameter int PCIE_TAG_W  = 6,
  parameter int CNT_W       = 32,
  parameter bit CLR_ON_RD   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stat_rd_op_start_valid,
  input  logic        stat_rd_op_finish_valid,
  input  logic [3:0]  stat_rd_op_finish_status,
  input  logic        stat_rd_req_start_valid,
  input  logic [12:0] stat_rd_req_start_len,
  input  logic        stat_rd_req_finish_valid,
  input  logic        stat_rd_req_timeout,
  input  logic        stat_rd_op_tbl_full,
  input  logic        stat_rd_no_tags,
  input  logic        stat_rd_tx_limit,
  input  logic        stat_rd_tx_stall,
  input  logic        stat_wr_op_start_valid,
  input  logic        stat_wr_op_finish_valid,
  input  logic [3:0]  stat_wr_op_finish_status,
  input  logic        stat_wr_req_start_valid,
  input  logic [12:0] stat_wr_req_start_len,
  input  logic        stat_wr_req_finish_valid,
  input  logic        stat_wr_op_tbl_full,
  input  logic        stat_wr_tx_limit,
  input  logic        stat_wr_tx_stall,
  input  logic        clr,
  input  logic        reg_rd_en,
  input  logic [3:0]  reg_rd_addr,
  output logic [31:0] reg_rd_data,
  output logic        reg_rd_ack
);

  localparam int RD_IF_W = PCIE_TAG_W + 1;
  localparam int WR_IF_W = WR_OP_TAG_W + 1;
  localparam int RD_N    = 7;   // plain read-side counters, indices 0..6
  localparam int WR_N    = 6;   // plain write-side counters, indices 8..13

  // Peak fields are 16 bits wide and counters are at most 32 bits wide
  if ((CNT_W < 1) || (CNT_W > 32) || (RD_OP_TAG_W < 1) ||
      (RD_IF_W > 16) || (WR_IF_W > 16)) begin : g_bad_param
    $error("cndm_micro_dma_stats: unsupported parameter set");
  end

  logic [CNT_W-1:0]   rd_inc_s [0:RD_N-1];
  logic [CNT_W-1:0]   wr_inc_s [0:WR_N-1];
  logic [CNT_W-1:0]   rd_cnt_s [0:RD_N-1];
  logic [CNT_W-1:0]   wr_cnt_s [0:WR_N-1];
  logic [CNT_W-1:0]   rd_nxt_unused_s [0:RD_N-1];
  logic [CNT_W-1:0]   wr_nxt_unused_s [0:WR_N-1];
  logic [RD_N-1:0]    rd_clr_s;
  logic [WR_N-1:0]    wr_clr_s;
  logic               rd_stall_s;
  logic               wr_stall_s;

  logic [RD_IF_W-1:0] rd_if_cnt_s;
  logic [RD_IF_W-1:0] rd_if_nxt_s;
  logic [WR_IF_W-1:0] wr_if_cnt_s;
  logic [WR_IF_W-1:0] wr_if_nxt_s;

  logic               peak_clr_s;
  logic [RD_IF_W-1:0] rd_peak_r;
  logic [RD_IF_W-1:0] rd_peak_base_s;
  logic [RD_IF_W-1:0] rd_peak_nxt_s;
  logic [WR_IF_W-1:0] wr_peak_r;
  logic [WR_IF_W-1:0] wr_peak_base_s;
  logic [WR_IF_W-1:0] wr_peak_nxt_s;

  stat_reg_t          sel_s;
  logic [31:0]        rd_mux_s;

  // Per-cycle increment for every plain counter (stall counts once per cycle)
  always_comb begin
    rd_stall_s  = stat_rd_op_tbl_full | stat_rd_no_tags | stat_rd_tx_limit | stat_rd_tx_stall;
    wr_stall_s  = stat_wr_op_tbl_full | stat_wr_tx_limit | stat_wr_tx_stall;
    rd_inc_s[0] = CNT_W'(stat_rd_op_start_valid);
    rd_inc_s[1] = CNT_W'(stat_rd_op_finish_valid);
    rd_inc_s[2] = CNT_W'(stat_rd_op_finish_valid && (stat_rd_op_finish_status != 4'd0));
    rd_inc_s[3] = CNT_W'(stat_rd_req_start_valid);
    if (stat_rd_req_start_valid) begin
      rd_inc_s[4] = CNT_W'(stat_rd_req_start_len);
    end else begin
      rd_inc_s[4] = '0;
    end
    rd_inc_s[5] = CNT_W'(stat_rd_req_timeout);
    rd_inc_s[6] = CNT_W'(rd_stall_s);
    wr_inc_s[0] = CNT_W'(stat_wr_op_start_valid);
    wr_inc_s[1] = CNT_W'(stat_wr_op_finish_valid);
    wr_inc_s[2] = CNT_W'(stat_wr_op_finish_valid && (stat_wr_op_finish_status != 4'd0));
    wr_inc_s[3] = CNT_W'(stat_wr_req_start_valid);
    if (stat_wr_req_start_valid) begin
      wr_inc_s[4] = CNT_W'(stat_wr_req_start_len);
    end else begin
      wr_inc_s[4] = '0;
    end
    wr_inc_s[5] = CNT_W'(wr_stall_s);
  end

  // Clear request per counter: global clr or an accepted clear-on-read hit
  always_comb begin
    for (int k = 0; k < RD_N; k++) begin
      rd_clr_s[k] = clr | (CLR_ON_RD & reg_rd_en & (reg_rd_addr == 4'(k)));
    end
    for (int k = 0; k < WR_N; k++) begin
      wr_clr_s[k] = clr | (CLR_ON_RD & reg_rd_en & (reg_rd_addr == 4'(k + 8)));
    end
    peak_clr_s = clr | (CLR_ON_RD & reg_rd_en & (reg_rd_addr == CNDM_DMA_STAT_PEAK));
  end

  for (genvar k = 0; k < RD_N; k++) begin : g_rd_ctr
    cndm_micro_stat_ctr #(.W(CNT_W), .SAT(1'b0)) u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (rd_inc_s[k]),
      .dec (1'b0),
      .clr (rd_clr_s[k]),
      .cnt (rd_cnt_s[k]),
      .nxt (rd_nxt_unused_s[k])
    );
  end

  for (genvar k = 0; k < WR_N; k++) begin : g_wr_ctr
    cndm_micro_stat_ctr #(.W(CNT_W), .SAT(1'b0)) u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (wr_inc_s[k]),
      .dec (1'b0),
      .clr (wr_clr_s[k]),
      .cnt (wr_cnt_s[k]),
      .nxt (wr_nxt_unused_s[k])
    );
  end

  // In-flight TLP counters are never cleared except by rst
  cndm_micro_stat_ctr #(.W(RD_IF_W), .SAT(1'b1)) u_rd_inflight (
    .clk (clk),
    .rst (rst),
    .inc (RD_IF_W'(stat_rd_req_start_valid)),
    .dec (stat_rd_req_finish_valid),
    .clr (1'b0),
    .cnt (rd_if_cnt_s),
    .nxt (rd_if_nxt_s)
  );

  cndm_micro_stat_ctr #(.W(WR_IF_W), .SAT(1'b1)) u_wr_inflight (
    .clk (clk),
    .rst (rst),
    .inc (WR_IF_W'(stat_wr_req_start_valid)),
    .dec (stat_wr_req_finish_valid),
    .clr (1'b0),
    .cnt (wr_if_cnt_s),
    .nxt (wr_if_nxt_s)
  );

  // Peak tracking: a clear rebases on the current in-flight value, then the
  // next in-flight value raises it if larger
  always_comb begin
    if (peak_clr_s) begin
      rd_peak_base_s = rd_if_cnt_s;
      wr_peak_base_s = wr_if_cnt_s;
    end else begin
      rd_peak_base_s = rd_peak_r;
      wr_peak_base_s = wr_peak_r;
    end
    if (rd_if_nxt_s > rd_peak_base_s) begin
      rd_peak_nxt_s = rd_if_nxt_s;
    end else begin
      rd_peak_nxt_s = rd_peak_base_s;
    end
    if (wr_if_nxt_s > wr_peak_base_s) begin
      wr_peak_nxt_s = wr_if_nxt_s;
    end else begin
      wr_peak_nxt_s = wr_peak_base_s;
    end
  end

  // Peak registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_peak_r <= '0;
      wr_peak_r <= '0;
    end else begin
      rd_peak_r <= rd_peak_nxt_s;
      wr_peak_r <= wr_peak_nxt_s;
    end
  end

  assign sel_s = stat_reg_t'(reg_rd_addr);

  // Read mux over pre-update register values, zero-extended to 32 bits
  always_comb begin
    rd_mux_s = 32'd0;
    case (sel_s)
      STAT_RD_OP_START: rd_mux_s = 32'(rd_cnt_s[0]);
      STAT_RD_OP_DONE:  rd_mux_s = 32'(rd_cnt_s[1]);
      STAT_RD_OP_ERR:   rd_mux_s = 32'(rd_cnt_s[2]);
      STAT_RD_REQ:      rd_mux_s = 32'(rd_cnt_s[3]);
      STAT_RD_BYTES:    rd_mux_s = 32'(rd_cnt_s[4]);
      STAT_RD_TIMEOUT:  rd_mux_s = 32'(rd_cnt_s[5]);
      STAT_RD_STALL:    rd_mux_s = 32'(rd_cnt_s[6]);
      STAT_RD_INFLIGHT: rd_mux_s = 32'(rd_if_cnt_s);
      STAT_WR_OP_START: rd_mux_s = 32'(wr_cnt_s[0]);
      STAT_WR_OP_DONE:  rd_mux_s = 32'(wr_cnt_s[1]);
      STAT_WR_OP_ERR:   rd_mux_s = 32'(wr_cnt_s[2]);
      STAT_WR_REQ:      rd_mux_s = 32'(wr_cnt_s[3]);
      STAT_WR_BYTES:    rd_mux_s = 32'(wr_cnt_s[4]);
      STAT_WR_STALL:    rd_mux_s = 32'(wr_cnt_s[5]);
      STAT_WR_INFLIGHT: rd_mux_s = 32'(wr_if_cnt_s);
      STAT_PEAK:        rd_mux_s = {16'(wr_peak_r), 16'(rd_peak_r)};
      default:          rd_mux_s = 32'd0;
    endcase
  end

  // Registered read response; a read coinciding with rst is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rd_ack  <= 1'b0;
      reg_rd_data <= 32'd0;
    end else begin
      reg_rd_ack <= reg_rd_en;
      if (reg_rd_en) begin
        reg_rd_data <= rd_mux_s;
      end else begin
        reg_rd_data <= reg_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_cndm_micro_dma_stats.sv
// Scoreboard bench: two instances (clear-on-read off / on) share stimulus.
// A behavioural model predicts each read when it is issued; monitors pop
// and compare whenever a DUT acknowledges.
module tb_cndm_micro_dma_stats;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stat_rd_op_start_valid, stat_rd_op_finish_valid;
  logic [3:0]  stat_rd_op_finish_status;
  logic        stat_rd_req_start_valid;
  logic [12:0] stat_rd_req_start_len;
  logic        stat_rd_req_finish_valid, stat_rd_req_timeout;
  logic        stat_rd_op_tbl_full, stat_rd_no_tags, stat_rd_tx_limit, stat_rd_tx_stall;
  logic        stat_wr_op_start_valid, stat_wr_op_finish_valid;
  logic [3:0]  stat_wr_op_finish_status;
  logic        stat_wr_req_start_valid;
  logic [12:0] stat_wr_req_start_len;
  logic        stat_wr_req_finish_valid;
  logic        stat_wr_op_tbl_full, stat_wr_tx_limit, stat_wr_tx_stall;
  logic        clr, reg_rd_en;
  logic [3:0]  reg_rd_addr;
  logic [31:0] data0, data1;
  logic        ack0, ack1;

  cndm_micro_dma_stats #(.CLR_ON_RD(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .stat_rd_op_start_valid(stat_rd_op_start_valid),
    .stat_rd_op_finish_valid(stat_rd_op_finish_valid),
    .stat_rd_op_finish_status(stat_rd_op_finish_status),
    .stat_rd_req_start_valid(stat_rd_req_start_valid),
    .stat_rd_req_start_len(stat_rd_req_start_len),
    .stat_rd_req_finish_valid(stat_rd_req_finish_valid),
    .stat_rd_req_timeout(stat_rd_req_timeout),
    .stat_rd_op_tbl_full(stat_rd_op_tbl_full), .stat_rd_no_tags(stat_rd_no_tags),
    .stat_rd_tx_limit(stat_rd_tx_limit), .stat_rd_tx_stall(stat_rd_tx_stall),
    .stat_wr_op_start_valid(stat_wr_op_start_valid),
    .stat_wr_op_finish_valid(stat_wr_op_finish_valid),
    .stat_wr_op_finish_status(stat_wr_op_finish_status),
    .stat_wr_req_start_valid(stat_wr_req_start_valid),
    .stat_wr_req_start_len(stat_wr_req_start_len),
    .stat_wr_req_finish_valid(stat_wr_req_finish_valid),
    .stat_wr_op_tbl_full(stat_wr_op_tbl_full), .stat_wr_tx_limit(stat_wr_tx_limit),
    .stat_wr_tx_stall(stat_wr_tx_stall),
    .clr(clr), .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(data0), .reg_rd_ack(ack0)
  );

  cndm_micro_dma_stats #(.CLR_ON_RD(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .stat_rd_op_start_valid(stat_rd_op_start_valid),
    .stat_rd_op_finish_valid(stat_rd_op_finish_valid),
    .stat_rd_op_finish_status(stat_rd_op_finish_status),
    .stat_rd_req_start_valid(stat_rd_req_start_valid),
    .stat_rd_req_start_len(stat_rd_req_start_len),
    .stat_rd_req_finish_valid(stat_rd_req_finish_valid),
    .stat_rd_req_timeout(stat_rd_req_timeout),
    .stat_rd_op_tbl_full(stat_rd_op_tbl_full), .stat_rd_no_tags(stat_rd_no_tags),
    .stat_rd_tx_limit(stat_rd_tx_limit), .stat_rd_tx_stall(stat_rd_tx_stall),
    .stat_wr_op_start_valid(stat_wr_op_start_valid),
    .stat_wr_op_finish_valid(stat_wr_op_finish_valid),
    .stat_wr_op_finish_status(stat_wr_op_finish_status),
    .stat_wr_req_start_valid(stat_wr_req_start_valid),
    .stat_wr_req_start_len(stat_wr_req_start_len),
    .stat_wr_req_finish_valid(stat_wr_req_finish_valid),
    .stat_wr_op_tbl_full(stat_wr_op_tbl_full), .stat_wr_tx_limit(stat_wr_tx_limit),
    .stat_wr_tx_stall(stat_wr_tx_stall),
    .clr(clr), .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(data1), .reg_rd_ack(ack1)
  );

  typedef struct {
    int          due;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state: model 0 = no clear-on-read, model 1 = clear-on-read
  logic [31:0] m_reg [2][16];
  int m_rd_if, m_wr_if;
  int m_rd_pk [2];
  int m_wr_pk [2];

  logic [3:0]  st_list [3] = '{4'd0, 4'd0, 4'd4};
  logic [12:0] len_list [3] = '{13'd4096, 13'd512, 13'd8191};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] m_read(input int m, input int a);
    if (a == 7) return 32'(m_rd_if);
    else if (a == 14) return 32'(m_wr_if);
    else if (a == 15) return 32'(m_wr_pk[m] * 65536 + m_rd_pk[m]);
    else return m_reg[m][a];
  endfunction

  // Amount register a grows by this cycle, straight from the register map
  function automatic logic [31:0] m_event(input int a);
    case (a)
      0:  return 32'(stat_rd_op_start_valid);
      1:  return 32'(stat_rd_op_finish_valid);
      2:  return 32'(stat_rd_op_finish_valid && stat_rd_op_finish_status != 4'd0);
      3:  return 32'(stat_rd_req_start_valid);
      4:  return stat_rd_req_start_valid ? 32'(stat_rd_req_start_len) : 32'd0;
      5:  return 32'(stat_rd_req_timeout);
      6:  return 32'(stat_rd_op_tbl_full || stat_rd_no_tags || stat_rd_tx_limit || stat_rd_tx_stall);
      8:  return 32'(stat_wr_op_start_valid);
      9:  return 32'(stat_wr_op_finish_valid);
      10: return 32'(stat_wr_op_finish_valid && stat_wr_op_finish_status != 4'd0);
      11: return 32'(stat_wr_req_start_valid);
      12: return stat_wr_req_start_valid ? 32'(stat_wr_req_start_len) : 32'd0;
      13: return 32'(stat_wr_op_tbl_full || stat_wr_tx_limit || stat_wr_tx_stall);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int step_if(input int v, input logic s, input logic f, input int maxv);
    if (s && !f) return (v < maxv) ? v + 1 : v;
    else if (f && !s) return (v > 0) ? v - 1 : 0;
    else return v;
  endfunction

  // Advance the model by the cycle whose inputs are currently driven
  task automatic model_step();
    exp_t e;
    int nrd, nwr, base;
    bit hit;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int a = 0; a < 16; a++) m_reg[m][a] = 32'd0;
        m_rd_pk[m] = 0;
        m_wr_pk[m] = 0;
      end
      m_rd_if = 0;
      m_wr_if = 0;
      return;
    end
    if (reg_rd_en) begin
      e.due = cyc + 1; e.addr = reg_rd_addr;
      e.data = m_read(0, int'(reg_rd_addr)); q0.push_back(e);
      e.data = m_read(1, int'(reg_rd_addr)); q1.push_back(e);
    end
    nrd = step_if(m_rd_if, stat_rd_req_start_valid, stat_rd_req_finish_valid, 127);
    nwr = step_if(m_wr_if, stat_wr_req_start_valid, stat_wr_req_finish_valid, 63);
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 14; a++) begin
        if (a != 7) begin
          hit = clr || (m == 1 && reg_rd_en && int'(reg_rd_addr) == a);
          m_reg[m][a] = (hit ? 32'd0 : m_reg[m][a]) + m_event(a);
        end
      end
      hit = clr || (m == 1 && reg_rd_en && reg_rd_addr == 4'd15);
      base = hit ? m_rd_if : m_rd_pk[m];
      m_rd_pk[m] = (nrd > base) ? nrd : base;
      base = hit ? m_wr_if : m_wr_pk[m];
      m_wr_pk[m] = (nwr > base) ? nwr : base;
    end
    m_rd_if = nrd;
    m_wr_if = nwr;
  endtask

  task automatic set_idle();
    rst = 1'b0; clr = 1'b0; reg_rd_en = 1'b0; reg_rd_addr = 4'd0;
    stat_rd_op_start_valid = 1'b0; stat_rd_op_finish_valid = 1'b0; stat_rd_op_finish_status = 4'd0;
    stat_rd_req_start_valid = 1'b0; stat_rd_req_start_len = 13'd0;
    stat_rd_req_finish_valid = 1'b0; stat_rd_req_timeout = 1'b0;
    stat_rd_op_tbl_full = 1'b0; stat_rd_no_tags = 1'b0; stat_rd_tx_limit = 1'b0; stat_rd_tx_stall = 1'b0;
    stat_wr_op_start_valid = 1'b0; stat_wr_op_finish_valid = 1'b0; stat_wr_op_finish_status = 4'd0;
    stat_wr_req_start_valid = 1'b0; stat_wr_req_start_len = 13'd0; stat_wr_req_finish_valid = 1'b0;
    stat_wr_op_tbl_full = 1'b0; stat_wr_tx_limit = 1'b0; stat_wr_tx_stall = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic rd(input int a);
    reg_rd_en = 1'b1;
    reg_rd_addr = 4'(a);
    tick();
  endtask

  task automatic mon(input int p, input logic ack, input logic [31:0] d);
    exp_t e;
    bit have = 1'b0;
    if (p == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      n_cmp++;
      if (ack !== 1'b1 || d !== e.data) begin
        n_bad++;
        $display("FAIL rd_dut%0d addr=%0d cyc=%0d: got ack=%b data=0x%08h, want ack=1 data=0x%08h",
                 p, e.addr, cyc, ack, d, e.data);
      end
    end else if (ack !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_ack_dut%0d cyc=%0d: got ack=%b, want ack=0", p, cyc, ack);
    end
  endtask

  // Monitors: compare on the falling edge, away from the sampling edge
  always @(negedge clk) begin
    if (cyc > 0) begin
      mon(0, ack0, data0);
      mon(1, ack1, data1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    // Reset state, back-to-back reads of every register
    for (int a = 0; a < 16; a++) rd(a);
    tick();
    // Read operations, one finishing with an error status
    repeat (3) begin stat_rd_op_start_valid = 1'b1; tick(); end
    for (int i = 0; i < 3; i++) begin
      stat_rd_op_finish_valid = 1'b1; stat_rd_op_finish_status = st_list[i]; tick();
    end
    rd(0); rd(1); rd(2);
    // Read TLPs and byte totals
    for (int i = 0; i < 3; i++) begin
      stat_rd_req_start_valid = 1'b1; stat_rd_req_start_len = len_list[i]; tick();
    end
    rd(3); rd(4); rd(7);
    // Write in-flight: up, simultaneous start/finish, then floored at zero
    repeat (5) begin stat_wr_req_start_valid = 1'b1; stat_wr_req_start_len = 13'd64; tick(); end
    rd(14); rd(15);
    stat_wr_req_start_valid = 1'b1; stat_wr_req_finish_valid = 1'b1; tick();
    rd(14);
    repeat (7) begin stat_wr_req_finish_valid = 1'b1; tick(); end
    rd(14); rd(15); rd(12); rd(11);
    // Stall levels: overlapping levels count once per cycle
    repeat (10) begin stat_rd_tx_stall = 1'b1; stat_rd_no_tags = 1'b1; tick(); end
    repeat (4) begin stat_rd_op_tbl_full = 1'b1; tick(); end
    rd(6);
    repeat (3) begin stat_wr_tx_limit = 1'b1; stat_wr_tx_stall = 1'b1; tick(); end
    rd(13);
    // Read coinciding with an increment
    repeat (2) begin stat_rd_req_start_valid = 1'b1; stat_rd_req_start_len = 13'd100; tick(); end
    reg_rd_en = 1'b1; reg_rd_addr = 4'd3;
    stat_rd_req_start_valid = 1'b1; stat_rd_req_start_len = 13'd100; tick();
    rd(3);
    // clr with outstanding TLPs, and clr with a same-cycle event
    repeat (3) begin stat_rd_req_finish_valid = 1'b1; tick(); end
    clr = 1'b1; tick();
    rd(3); rd(7); rd(15); rd(4);
    clr = 1'b1; stat_wr_op_start_valid = 1'b1; tick();
    rd(8);
    // Write in-flight ceiling
    repeat (70) begin stat_wr_req_start_valid = 1'b1; tick(); end
    rd(14); rd(15);
    repeat (70) begin stat_wr_req_finish_valid = 1'b1; tick(); end
    rd(14);
    // rst with a read pending in the same cycle
    stat_rd_op_start_valid = 1'b1; tick();
    reg_rd_en = 1'b1; reg_rd_addr = 4'd0; rst = 1'b1; tick();
    for (int a = 0; a < 16; a++) rd(a);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      stat_rd_op_start_valid   = ($urandom_range(0, 3) == 0);
      stat_rd_op_finish_valid  = ($urandom_range(0, 3) == 0);
      stat_rd_op_finish_status = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      stat_rd_req_start_valid  = ($urandom_range(0, 2) == 0);
      stat_rd_req_start_len    = 13'($urandom_range(0, 8191));
      stat_rd_req_finish_valid = ($urandom_range(0, 2) == 0);
      stat_rd_req_timeout      = ($urandom_range(0, 15) == 0);
      stat_rd_op_tbl_full      = ($urandom_range(0, 7) == 0);
      stat_rd_no_tags          = ($urandom_range(0, 7) == 0);
      stat_rd_tx_limit         = ($urandom_range(0, 7) == 0);
      stat_rd_tx_stall         = ($urandom_range(0, 7) == 0);
      stat_wr_op_start_valid   = ($urandom_range(0, 3) == 0);
      stat_wr_op_finish_valid  = ($urandom_range(0, 3) == 0);
      stat_wr_op_finish_status = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      stat_wr_req_start_valid  = ($urandom_range(0, 1) == 0);
      stat_wr_req_start_len    = 13'($urandom_range(0, 8191));
      stat_wr_req_finish_valid = ($urandom_range(0, 2) == 0);
      stat_wr_op_tbl_full      = ($urandom_range(0, 7) == 0);
      stat_wr_tx_limit         = ($urandom_range(0, 7) == 0);
      stat_wr_tx_stall         = ($urandom_range(0, 7) == 0);
      clr                      = ($urandom_range(0, 96) == 0);
      rst                      = ($urandom_range(0, 499) == 0);
      reg_rd_en                = ($urandom_range(0, 1) == 0);
      reg_rd_addr              = 4'($urandom_range(0, 15));
      tick();
    end
    tick();
    for (int a = 0; a < 16; a++) rd(a);
    repeat (4) tick();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d reads unacknowledged, want 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cndm_micro_dma_stats.md
Name: cndm_micro_dma_stats

Overview:
- Statistics collector sitting directly downstream of the PCIe DMA interface in the Corundum-micro PCIe core.
- Consumes the per-cycle stat_rd_* / stat_wr_* pulse and level outputs of the DMA interface.
- Accumulates them into sixteen 32-bit registers: event counts, byte totals, stall cycles, in-flight and peak in-flight request counts.
- Exposes the registers through a one-cycle-latency register read port for the control register block, with optional clear-on-read.

Parameters:
- RD_OP_TAG_W, 6: width of stat_rd_op_*_tag (log2 RD_OP_TBL_SIZE).
- WR_OP_TAG_W, 5: width of stat_wr_op_*_tag and stat_wr_req_*_tag (log2 WR_OP_TBL_SIZE).
- PCIE_TAG_W, 6: width of stat_rd_req_*_tag (log2 PCIE_TAG_CNT).
- CNT_W, 32: counter width, 1 to 32; read data is zero-extended to 32 bits.
- CLR_ON_RD, 1'b0: when 1, an accepted read clears the addressed register.

Ports:
- clk  in  1  clock (pcie_clk domain)
- rst  in  1  synchronous active-high reset
- stat_rd_op_start_valid  in  1  read op started
- stat_rd_op_finish_valid / stat_rd_op_finish_status  in  1 / 4  read op finished, status (0 = OK)
- stat_rd_req_start_valid / stat_rd_req_start_len  in  1 / 13  read TLP issued, byte length
- stat_rd_req_finish_valid  in  1  read TLP completed
- stat_rd_req_timeout  in  1  completion timeout pulse
- stat_rd_op_tbl_full, stat_rd_no_tags, stat_rd_tx_limit, stat_rd_tx_stall  in  1 each  read stall levels
- stat_wr_op_start_valid  in  1  write op started
- stat_wr_op_finish_valid / stat_wr_op_finish_status  in  1 / 4  write op finished, status
- stat_wr_req_start_valid / stat_wr_req_start_len  in  1 / 13  write TLP issued, byte length
- stat_wr_req_finish_valid  in  1  write TLP retired
- stat_wr_op_tbl_full, stat_wr_tx_limit, stat_wr_tx_stall  in  1 each  write stall levels
- clr  in  1  clear all registers (pulse)
- reg_rd_en  in  1  read strobe
- reg_rd_addr  in  4  register index
- reg_rd_data  out  32  read data
- reg_rd_ack  out  1  read data valid

Behaviour:
- Reset behaviour:
  - All registers, in-flight counters and peaks are 0.
  - reg_rd_ack is 0 and reg_rd_data is 0.
- Register map:
  - 0 RD_OP_START; 1 RD_OP_DONE; 2 RD_OP_ERR (finish with status != 0).
  - 3 RD_REQ; 4 RD_BYTES (sum of start_len); 5 RD_TIMEOUT.
  - 6 RD_STALL: cycles where any read stall level is high; counts 1 per cycle regardless of how many are high.
  - 7 RD_INFLIGHT: current outstanding read TLPs.
  - 8 WR_OP_START; 9 WR_OP_DONE; 10 WR_OP_ERR; 11 WR_REQ; 12 WR_BYTES; 13 WR_STALL; 14 WR_INFLIGHT.
  - 15 PEAK: [15:0] read peak in-flight, [31:16] write peak in-flight.
- Counter arithmetic:
  - Event, byte and stall counters wrap modulo 2^CNT_W.
  - Byte counters add the 13-bit length zero-extended.
  - RD_OP_DONE also counts error finishes.
- In-flight counters:
  - Read in-flight is PCIE_TAG_W+1 bits; write in-flight is WR_OP_TAG_W+1 bits.
  - Start +1, finish -1; start and finish in the same cycle leaves the value unchanged.
  - Finish at 0 with no start holds at 0 (no underflow).
  - Start at the all-ones value holds (no overflow).
  - Peak is updated whenever the next in-flight value exceeds the stored peak.
- Update timing: all updates are registered; a stat pulse in cycle N is visible on a read issued in cycle N+1.
- Read port:
  - reg_rd_en in cycle N gives reg_rd_ack=1 and reg_rd_data valid in cycle N+1; ack is 0 otherwise.
  - Back-to-back reads are accepted every cycle.
  - Returned data is the register value before any update in cycle N.
- Clear-on-read (CLR_ON_RD=1): the addressed register is cleared in cycle N, except that an increment arriving in cycle N is retained (register becomes the increment).
  - RD_INFLIGHT and WR_INFLIGHT are never cleared by a read.
  - A read of PEAK resets the peaks to the current in-flight values.
- clr:
  - Same precedence as clear-on-read, applied to all registers: same-cycle events are kept.
  - In-flight counters are not cleared, so outstanding TLP accounting survives.
  - Peaks reload from the current in-flight values.
- rst mid-operation clears everything, including in-flight counters; any read pending in the same cycle produces no ack.

Decomposition:
- Shared package cndm_micro_pkg holds:
  - register index constants CNDM_DMA_STAT_RD_OP_START … CNDM_DMA_STAT_PEAK;
  - a stat_reg_t enum covering those indices.
- One natural sub-module: cndm_micro_stat_ctr.
  - Inputs: increment amount, clear, hold-floor/ceiling mode.
  - Instantiated once per register, with the in-flight variant parameterized.

Test Plan:
- Reset, then read addresses 0–15 back-to-back -> each ack one cycle after en, all data 0.
- 3 rd_op_start pulses; 3 finishes with status 0,0,4 -> RD_OP_START=3, RD_OP_DONE=3, RD_OP_ERR=1.
- rd_req_start with len 4096, 512, 8191 -> RD_REQ=3, RD_BYTES=12799.
- In-flight sequence:
  - Stimulus: 5 wr_req starts, then start+finish in the same cycle, then 7 finishes.
  - Response: WR_INFLIGHT=5 then 5 then 0 (floored), PEAK[31:16]=5.
- Stall levels:
  - Stimulus: tx_stall and no_tags both high for 10 cycles overlapping, tbl_full high for 4 further cycles.
  - Response: RD_STALL=14.
- CLR_ON_RD=1:
  - Stimulus: read RD_REQ (=2) in the same cycle as a rd_req_start pulse.
  - Response: returns 2; next read returns 1. clr with 3 TLPs in flight -> RD_REQ=0, RD_INFLIGHT=3, PEAK[15:0]=3.
